// File: rtl/fcmp_arb.sv
// Two-port arbitrated FLT/FLE/FEQ sequencer around one shared "x1 < x2" flt cell.
// Optional NaN bypass (no comparator pass, result 0) when FCMP_NAN_EN is defined.

module fcmp_flt (
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        lt
);
  logic        s1, s2;
  logic [30:0] m1, m2;

  assign s1 = x1[31];
  assign s2 = x2[31];
  assign m1 = x1[30:0];
  assign m2 = x2[30:0];

  // Sign-magnitude ordering; +0 and -0 compare equal.
  always_comb begin
    lt = 1'b0;
    if ((m1 == '0) && (m2 == '0)) lt = 1'b0;
    else if (s1 != s2)            lt = s1;
    else if (!s1)                 lt = (m1 < m2);
    else                          lt = (m1 > m2);
  end
endmodule

module fcmp_arb #(
  parameter bit FIRST_PRIO = 1'b0,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp0_v,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic             rsp1_v,
  output logic             busy,
  output logic [CNT_W-1:0] pass_cnt
);
  localparam logic [1:0] OP_FLT = 2'b00;
  localparam logic [1:0] OP_FLE = 2'b01;
  localparam logic [1:0] OP_FEQ = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {IDLE, P1, P2, RESP} state_t;

  state_t      state, state_nxt;
  logic [31:0] a_q, b_q;
  logic [1:0]  op_q;
  logic        gid_q, prio_q, r1_q, r2_q;

  logic        any_req, gnt, acc, hs, nan_in;
  logic [31:0] in_a, in_b;
  logic [1:0]  in_op;
  logic [31:0] cmp_x1, cmp_x2;
  logic        cmp_lt, swap, res_v;

`ifdef FCMP_NAN_EN
  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != '0);
  endfunction
`endif

  // Arbitration: a lone requester wins outright; contention follows the pointer.
  assign any_req = req0_valid | req1_valid;
  assign gnt     = (req0_valid & req1_valid) ? prio_q : req1_valid;
  assign acc     = (state == IDLE) & any_req;
  assign hs      = (state == RESP) & (gid_q ? rsp1_ready : rsp0_ready);

  assign in_a  = gnt ? req1_a  : req0_a;
  assign in_b  = gnt ? req1_b  : req0_b;
  assign in_op = gnt ? req1_op : req0_op;

`ifdef FCMP_NAN_EN
  assign nan_in = is_nan(in_a) | is_nan(in_b);
`else
  assign nan_in = 1'b0;
`endif

  // FLE and the FEQ second pass evaluate b < a.
  assign swap   = (state == P2) | (op_q == OP_FLE);
  assign cmp_x1 = swap ? b_q : a_q;
  assign cmp_x2 = swap ? a_q : b_q;

  fcmp_flt u_flt (
    .x1 (cmp_x1),
    .x2 (cmp_x2),
    .lt (cmp_lt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (acc) state_nxt = nan_in ? RESP : P1;
      P1:      state_nxt = (op_q == OP_FEQ) ? P2 : RESP;
      P2:      state_nxt = RESP;
      RESP:    if (hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latch at the accept edge; comparator results in P1/P2.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_FLT;
      gid_q    <= 1'b0;
      prio_q   <= FIRST_PRIO;
      r1_q     <= 1'b0;
      r2_q     <= 1'b0;
      pass_cnt <= '0;
    end else begin
      if (acc) begin
        a_q   <= in_a;
        b_q   <= in_b;
        // A bypassed NaN request is recorded as the reserved op so it answers 0.
        op_q  <= nan_in ? OP_RSV : in_op;
        gid_q <= gnt;
      end
      if (state == P1) r1_q <= cmp_lt;
      if (state == P2) r2_q <= cmp_lt;
      if (((state == P1) || (state == P2)) && (pass_cnt != {CNT_W{1'b1}}))
        pass_cnt <= pass_cnt + CNT_W'(1);
      if (hs) prio_q <= ~gid_q;
    end
  end

  always_comb begin
    res_v = 1'b0;
    unique case (op_q)
      OP_FLT:  res_v = r1_q;
      OP_FLE:  res_v = ~r1_q;
      OP_FEQ:  res_v = ~r1_q & ~r2_q;
      default: res_v = 1'b0;
    endcase
  end

  // Ready is gated by rstn so nothing is offered while reset is held.
  always_comb begin
    req0_ready = rstn & acc & ~gnt;
    req1_ready = rstn & acc &  gnt;
    rsp0_valid = (state == RESP) & ~gid_q;
    rsp1_valid = (state == RESP) &  gid_q;
    rsp0_v     = rsp0_valid & res_v;
    rsp1_v     = rsp1_valid & res_v;
    busy       = (state != IDLE);
  end
endmodule

// File: tb/tb_fcmp_arb.sv
// Directed bench for fcmp_arb: vector table plus contention, backpressure and reset sequences.
// Expectations for the NaN case follow FCMP_NAN_EN.

module tb_fcmp_arb;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rstn;
  logic             req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_v;
  logic             req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_v;
  logic [1:0]       req0_op, req1_op;
  logic [31:0]      req0_a, req0_b, req1_a, req1_b;
  logic             busy;
  logic [CNT_W-1:0] pass_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  fcmp_arb #(.FIRST_PRIO(1'b0), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rsp0_ready),
    .rsp0_v     (rsp0_v),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rsp1_ready),
    .rsp1_v     (rsp1_v),
    .busy       (busy),
    .pass_cnt   (pass_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          port;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    bit          ev;
    int          lat;
    int          np;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  // Called just after raising valid at a negedge; returns 1 time unit after the accept edge.
  task automatic wait_accept(input bit port, input string name);
    bit ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      #1;
      if (port ? req1_ready : req0_ready) ok = 1'b1;
      else @(negedge clk);
    end
    chk({name, "_acc"}, 32'(ok), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_op(input bit port, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit ev, input int elat,
                       input int npass, input string name);
    int lat = 0;
    bit got = 1'b0;
    bit other = 1'b0;
    logic v = 1'b0;
    @(negedge clk);
    if (port) begin
      req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
    end else begin
      req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
    end
    wait_accept(port, name);
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 32'hDEADBEEF; req0_b = 32'h7F7FFFFF;
    req1_a = 32'hDEADBEEF; req1_b = 32'h7F7FFFFF;
    for (int c = 1; c <= 10 && !got; c++) begin
      @(negedge clk);
      if (port ? rsp0_valid : rsp1_valid) other = 1'b1;
      if (port ? rsp1_valid : rsp0_valid) begin
        got = 1'b1;
        lat = c;
        v = port ? rsp1_v : rsp0_v;
      end
    end
    chk({name, "_lat"}, 32'(lat), 32'(elat));
    chk({name, "_v"}, 32'(v), 32'(ev));
    chk({name, "_other"}, 32'(other), 32'd0);
    @(posedge clk); #1;
    exp_cnt = sat(exp_cnt + npass);
    chk({name, "_cnt"}, 32'(pass_cnt), 32'(exp_cnt));
    chk({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit grants[4];
    int ng, nr, nan_lat, nan_np;
    bit hit;

    vt[0]  = '{1'b0, 2'b00, 32'h3F800000, 32'h40000000, 1'b1, 2, 1};
    vt[1]  = '{1'b1, 2'b10, 32'h00000000, 32'h80000000, 1'b1, 3, 2};
    vt[2]  = '{1'b1, 2'b01, 32'hBF800000, 32'hBF800000, 1'b1, 2, 1};
    vt[3]  = '{1'b0, 2'b00, 32'h40000000, 32'h3F800000, 1'b0, 2, 1};
    vt[4]  = '{1'b0, 2'b01, 32'h80000000, 32'h00000000, 1'b1, 2, 1};
    vt[5]  = '{1'b1, 2'b10, 32'h3F800000, 32'h3F800001, 1'b0, 3, 2};
    vt[6]  = '{1'b0, 2'b00, 32'hBF800000, 32'h3F800000, 1'b1, 2, 1};
    vt[7]  = '{1'b1, 2'b00, 32'hC0000000, 32'hBF800000, 1'b1, 2, 1};
    vt[8]  = '{1'b0, 2'b11, 32'h3F800000, 32'h40000000, 1'b0, 2, 1};
    vt[9]  = '{1'b1, 2'b01, 32'h40000000, 32'h3F800000, 1'b0, 2, 1};
    vt[10] = '{1'b0, 2'b00, 32'h00000000, 32'h80000000, 1'b0, 2, 1};
    vt[11] = '{1'b0, 2'b10, 32'h41200000, 32'h41200000, 1'b1, 3, 2};

    rstn = 1'b0;
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_op = 2'b00; req1_a = '0; req1_b = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    chk("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    chk("rst_rsp_v", 32'({rsp0_v, rsp1_v}), 32'd0);
    chk("rst_pass_cnt", 32'(pass_cnt), 32'd0);
    req0_valid = 1'b0;
    rstn = 1'b1;

    // Continuous contention straight out of reset: expect grants 0,1,0,1.
    @(negedge clk);
    req0_op = 2'b00; req0_a = 32'h3F800000; req0_b = 32'h40000000;
    req1_op = 2'b00; req1_a = 32'h40000000; req1_b = 32'h3F800000;
    req0_valid = 1'b1; req1_valid = 1'b1;
    ng = 0; nr = 0;
    for (int c = 0; c < 60 && nr < 4; c++) begin
      #1;
      if (req0_ready && req1_ready) chk("cont_dual_ready", 32'd1, 32'd0);
      if (req0_ready || req1_ready) begin
        if (ng < 4) grants[ng] = req1_ready;
        ng++;
      end
      if (rsp0_valid) begin chk("cont_rsp0_v", 32'(rsp0_v), 32'd1); nr++; end
      if (rsp1_valid) begin chk("cont_rsp1_v", 32'(rsp1_v), 32'd0); nr++; end
      if (ng == 4 && req0_valid) begin
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("cont_ngrant", 32'(ng), 32'd4);
    chk("cont_nrsp", 32'(nr), 32'd4);
    chk("cont_order", 32'({grants[0], grants[1], grants[2], grants[3]}), 32'b0101);
    @(posedge clk); #1;
    exp_cnt = 4;
    chk("cont_cnt", 32'(pass_cnt), 32'(exp_cnt));

    for (int i = 0; i < 12; i++)
      do_op(vt[i].port, vt[i].op, vt[i].a, vt[i].b, vt[i].ev, vt[i].lat, vt[i].np,
            $sformatf("vec%0d", i));

`ifdef FCMP_NAN_EN
    nan_lat = 1; nan_np = 0;
`else
    nan_lat = 2; nan_np = 1;
`endif
    do_op(1'b0, 2'b01, 32'h7FC00000, 32'h3F800000, 1'b0, nan_lat, nan_np, "nan_fle");

    // Backpressure: port 0 result held while port 1 waits; port 1 wins afterwards.
    @(negedge clk);
    rsp0_ready = 1'b0;
    req0_op = 2'b00; req0_a = 32'h3F800000; req0_b = 32'h40000000; req0_valid = 1'b1;
    wait_accept(1'b0, "bp");
    req1_op = 2'b00; req1_a = 32'h40000000; req1_b = 32'h3F800000; req1_valid = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 10 && !hit; c++) begin
      @(negedge clk);
      hit = rsp0_valid;
    end
    chk("bp_rsp_seen", 32'(hit), 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(rsp0_valid), 32'd1);
      chk("bp_v", 32'(rsp0_v), 32'd1);
      chk("bp_ready_block", 32'({req0_ready, req1_ready}), 32'd0);
      chk("bp_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    rsp0_ready = 1'b1;
    @(posedge clk); #1;
    exp_cnt = sat(exp_cnt + 1);
    chk("bp_cnt", 32'(pass_cnt), 32'(exp_cnt));
    chk("bp_next_grant", 32'({req0_ready, req1_ready}), 32'b01);
    req0_valid = 1'b0;
    @(posedge clk); #1;
    req1_valid = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 10 && !hit; c++) begin
      @(negedge clk);
      hit = rsp1_valid;
    end
    chk("bp_p1_seen", 32'(hit), 32'd1);
    chk("bp_p1_v", 32'(rsp1_v), 32'd0);
    @(posedge clk); #1;
    exp_cnt = sat(exp_cnt + 1);
    chk("bp_p1_cnt", 32'(pass_cnt), 32'(exp_cnt));

    // Reset during P2 of an FEQ abandons it.
    @(negedge clk);
    req1_op = 2'b10; req1_a = 32'h00000000; req1_b = 32'h80000000; req1_valid = 1'b1;
    wait_accept(1'b1, "rstp2");
    req1_valid = 1'b0;
    @(posedge clk); #1;
    chk("rstp2_busy", 32'(busy), 32'd1);
    rstn = 1'b0;
    #1;
    chk("rstp2_clear", 32'({busy, rsp0_valid, rsp1_valid, rsp1_v}), 32'd0);
    chk("rstp2_cnt", 32'(pass_cnt), 32'd0);
    exp_cnt = 0;
    @(negedge clk);
    rstn = 1'b1;
    hit = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp0_valid || rsp1_valid || busy) hit = 1'b1;
    end
    chk("rstp2_no_rsp", 32'(hit), 32'd0);
    do_op(1'b0, 2'b00, 32'h3F800000, 32'h40000000, 1'b1, 2, 1, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
